// File: rtl/iob_bus_demux.sv
// IOb bus demultiplexer: one master to N_SLAVES slaves, read responses kept in order by a
// routing FIFO. Optional macro IOB_BUS_DEMUX_ERR_EN adds unmapped-address error responses.
module iob_bus_demux #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_SLAVES  = 4,
    parameter int P_SLAVES  = ADDR_W - 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cke_i,
`ifdef IOB_BUS_DEMUX_ERR_EN
    output logic                         err_o,
`endif
    input  logic                         m_avalid_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic [DATA_W/8-1:0]          m_wstrb_i,
    output logic                         m_ready_o,
    output logic                         m_rvalid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic [N_SLAVES-1:0]          s_avalid_o,
    output logic [N_SLAVES*ADDR_W-1:0]   s_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]   s_wdata_o,
    output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb_o,
    input  logic [N_SLAVES-1:0]          s_ready_i,
    input  logic [N_SLAVES-1:0]          s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i
);

    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [SEL_W:0]   N_SLV    = (SEL_W + 1)'(N_SLAVES);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SLAVES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] idx;
    } route_t;

    route_t           fifo_mem [0:MAX_OUTST-1];
    route_t           last_route;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [SEL_W-1:0]  sel;
    logic              unmapped;
    route_t            req_route;
    route_t            head;
    logic              is_read;
    logic              empty;
    logic              full;
    logic              stall;
    logic              slave_ready;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (MAX_OUTST == 1) ? '0 : p + 1'b1;
    endfunction

    assign s_addr_o  = {N_SLAVES{m_addr_i}};
    assign s_wdata_o = {N_SLAVES{m_wdata_i}};
    assign s_wstrb_o = {N_SLAVES{m_wstrb_i}};

    assign sel           = m_addr_i[P_SLAVES -: SEL_W];
    assign unmapped      = ({1'b0, sel} >= N_SLV);
    assign req_route.idx = unmapped ? LAST_IDX : sel;
`ifdef IOB_BUS_DEMUX_ERR_EN
    assign req_route.err = unmapped;
    assign slave_ready   = unmapped ? 1'b1 : s_ready_i[req_route.idx];
`else
    assign req_route.err = 1'b0;
    assign slave_ready   = s_ready_i[req_route.idx];
`endif

    // Reset forces the FIFO to look empty so the master sees a clean bus immediately.
    assign empty   = rst_i || (count == '0);
    assign full    = !rst_i && (count == CNT_FULL);
    assign head    = fifo_mem[rd_ptr];
    assign is_read = (m_wstrb_i == '0);

    always_comb begin
        head_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (head.idx == SEL_W'(i)) head_rdata = s_rdata_i[i*DATA_W +: DATA_W];
        end
    end

    assign m_rvalid_o = !empty && (head.err || s_rvalid_i[head.idx]);
    assign m_rdata_o  = empty ? '0 : (head.err ? '1 : head_rdata);
    assign pop        = m_rvalid_o;

    // A full FIFO still accepts a read when the head pops in the same cycle.
    assign stall     = is_read && ((full && !pop) || (!empty && (req_route != last_route)));
    assign m_ready_o = slave_ready && !stall;
    assign accept    = m_avalid_i && m_ready_o && cke_i;
    assign push      = accept && is_read;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s_avalid_o = '0;
        if (m_avalid_i && !stall && !req_route.err) s_avalid_o[req_route.idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cke_i) begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (cke_i && push) begin
            fifo_mem[wr_ptr] <= req_route;
            last_route       <= req_route;
        end
    end

`ifdef IOB_BUS_DEMUX_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                     err_q <= 1'b0;
        else if (accept && unmapped)   err_q <= 1'b1;
    end

    assign err_o = err_q;
`endif

endmodule

// File: doc/iob_bus_demux.md
IOB_BUS_DEMUX -- requirements
Module: iob_bus_demux

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; wstrb width is DATA_W/8.
REQ-003 SHALL have parameter N_SLAVES, default 4, range 2..16: slave count; SEL_W = clog2(N_SLAVES).
REQ-004 SHALL have parameter P_SLAVES, default ADDR_W-2: MSB position of the select field addr[P_SLAVES -: SEL_W].
REQ-005 SHALL have parameter MAX_OUTST, default 4, a power of 2 from 1 to 16: maximum number of outstanding reads.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock; all state updates on rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 cke_i  in  1  clock enable; state holds when low.
REQ-010 m_avalid_i / m_addr_i / m_wdata_i / m_wstrb_i  in  1/ADDR_W/DATA_W/DATA_W/8  master request.
REQ-011 m_ready_o / m_rvalid_o / m_rdata_o  out  1/1/DATA_W  master response.
REQ-012 s_avalid_o / s_addr_o / s_wdata_o / s_wstrb_o  out  N_SLAVES x (1/ADDR_W/DATA_W/DATA_W/8), flattened with slave 0 at the LSBs.
REQ-013 s_ready_i / s_rvalid_i / s_rdata_i  in  N_SLAVES x (1/1/DATA_W), flattened.
REQ-014 err_o  out  1  sticky unmapped-access flag; present only with IOB_BUS_DEMUX_ERR_EN.

Function
REQ-015 A request SHALL be accepted in a cycle where m_avalid_i=1, m_ready_o=1 and cke_i=1; a read has wstrb=0, a write has wstrb!=0.
REQ-016 addr, wdata and wstrb SHALL be broadcast unmodified to all slaves; only the selected slave's s_avalid_o bit SHALL equal m_avalid_i AND NOT stall, and all others SHALL be 0.
REQ-017 m_ready_o SHALL be s_ready_i[sel] AND NOT stall; the request path adds 0 cycles of latency.
REQ-018 The block SHALL contain a routing FIFO of depth MAX_OUTST with entries of SEL_W+1 bits (slave index plus error bit) and an occupancy counter of clog2(MAX_OUTST)+1 bits.
REQ-019 Each accepted read SHALL push its target index; writes SHALL push nothing and produce no rvalid.
REQ-020 stall SHALL be 1 when the FIFO is full and the request is a read, or when the FIFO is non-empty and the read targets a slave different from the newest FIFO entry; this keeps responses in order.
REQ-021 m_rvalid_o SHALL equal s_rvalid_i[head] when the FIFO is non-empty, with m_rdata_o = s_rdata_i[head]; the response is combinational and adds no latency.
REQ-022 m_rvalid_o SHALL cause a FIFO pop in the same cycle.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged, and the pop SHALL be allowed when the FIFO is full.
REQ-024 s_rvalid_i from any slave other than head, or with an empty FIFO, SHALL be ignored.
REQ-025 When the FIFO is empty, m_rvalid_o SHALL be 0 and m_rdata_o SHALL be 0.
REQ-026 The FIFO read and write pointers SHALL wrap modulo MAX_OUTST.

Reset
REQ-027 While rst_i=1 at a clock edge, pointers and occupancy SHALL clear to 0 and err_o SHALL clear to 0, regardless of cke_i.
REQ-028 Reads outstanding at reset SHALL be discarded, and later rvalids for them SHALL be ignored per REQ-024.
REQ-029 During reset, m_ready_o SHALL follow REQ-017 with an empty FIFO; s_avalid_o SHALL follow m_avalid_i.

Configuration
REQ-030 Macro IOB_BUS_DEMUX_ERR_EN SHALL enable unmapped-address handling.
REQ-031 With IOB_BUS_DEMUX_ERR_EN defined, a select value >= N_SLAVES SHALL assert no s_avalid_o bit and SHALL give m_ready_o=1 (subject to stall).
REQ-032 With IOB_BUS_DEMUX_ERR_EN defined, an unmapped read SHALL push an error entry; at head, that entry SHALL produce m_rvalid_o=1 one cycle later with m_rdata_o all ones, then pop.
REQ-033 With IOB_BUS_DEMUX_ERR_EN defined, any unmapped accept SHALL set err_o=1 until reset.
REQ-034 Without IOB_BUS_DEMUX_ERR_EN, a select value >= N_SLAVES SHALL route to slave N_SLAVES-1, the error bit SHALL be unused, and err_o SHALL be absent.

Verification
REQ-035 Write 0x11 to slave 2 (sel=2): s_avalid_o = 4'b0100 and wdata 0x11 appear the same cycle; m_ready_o mirrors s_ready_i[2]; no m_rvalid_o.
REQ-036 Four back-to-back reads to slave 1 with MAX_OUTST=4 and delayed rvalid: a fifth read sees m_ready_o=0 until the first rvalid, then is accepted in the pop cycle.
REQ-037 Read slave 0, then read slave 3 before slave 0 responds: slave 3 is not accessed and m_ready_o=0 until slave 0 returns 0xA5A5A5A5, and that value appears on m_rdata_o.
REQ-038 Stray s_rvalid_i[2]=1 with an empty FIFO: m_rvalid_o stays 0.
REQ-039 With IOB_BUS_DEMUX_ERR_EN and N_SLAVES=3, a read at sel=3: no s_avalid_o, m_rvalid_o one cycle later with rdata 0xFFFFFFFF, and err_o=1 until rst_i.
REQ-040 Assert rst_i with 2 reads outstanding: occupancy returns to 0; a new read to another slave is accepted the next cycle.
